// File: rtl/input_batch_packer.sv
// input_batch_packer: packs per-channel RGB pixels into tagged batches; one-cycle valid strobe per batch.
// Optional: define INPUT_PACKER_PAD_REPEAT_EN to pad partial batches with the last valid pixel of each lane.
module input_batch_packer #(
    parameter int unsigned CHANNEL_COUNT = 3,
    parameter int unsigned PIXEL_BITS    = 8,
    parameter int unsigned BATCH_SIZE    = 16,
    parameter int unsigned MAX_WIDTH     = 1920,
    parameter int unsigned MAX_HEIGHT    = 1080,
    localparam int unsigned MAX_BATCHES  = (MAX_WIDTH + BATCH_SIZE - 1) / BATCH_SIZE,
    localparam int unsigned ADDR_BITS    = (MAX_BATCHES > 1) ? $clog2(MAX_BATCHES) : 1,
    localparam int unsigned ROW_BITS     = (MAX_HEIGHT > 1) ? $clog2(MAX_HEIGHT) : 1,
    localparam int unsigned WIDTH_BITS   = $clog2(MAX_WIDTH + 1),
    localparam int unsigned COLOR_BITS   = CHANNEL_COUNT * PIXEL_BITS,
    localparam int unsigned LANE_BITS    = BATCH_SIZE * PIXEL_BITS,
    localparam int unsigned DATA_BITS    = CHANNEL_COUNT * LANE_BITS
) (
    input  logic                  I_rgb_clk,
    input  logic                  I_rst,
    input  logic                  I_rgb_de,
    input  logic                  I_rgb_vs,
    input  logic [COLOR_BITS-1:0] I_rgb_color,
    output logic                  O_batch_valid,
    output logic [DATA_BITS-1:0]  O_batch_data,
    output logic [BATCH_SIZE-1:0] O_batch_mask,
    output logic [ADDR_BITS-1:0]  O_batch_addr,
    output logic [ROW_BITS-1:0]   O_batch_row,
    output logic                  O_batch_first,
    output logic                  O_batch_last,
    output logic [WIDTH_BITS-1:0] O_line_width,
    output logic                  O_overflow
);

    localparam int unsigned FILL_BITS = $clog2(BATCH_SIZE);

    typedef enum logic [1:0] {
        ST_WAIT_FRAME,
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t                state;
    logic                  de_q;
    logic                  vs_q;
    logic [FILL_BITS-1:0]  fill;
    logic                  pending;
    logic [DATA_BITS-1:0]  asm_data;
    logic [ADDR_BITS-1:0]  addr_cnt;
    logic                  addr_full;
    logic [ROW_BITS-1:0]   row_cnt;
    logic                  row_full;
    logic                  first_flag;
    logic [WIDTH_BITS-1:0] pix_cnt;

    logic                  vs_rise;
    logic                  de_fall;
    logic                  in_frame;
    logic                  emit_full;
    logic                  emit_part;
    logic                  emit;
    logic                  capture;
    logic [BATCH_SIZE-1:0] slot_used;
    logic [DATA_BITS-1:0]  emit_data;

    assign vs_rise   = I_rgb_vs & ~vs_q;
    assign de_fall   = ~I_rgb_de & de_q;
    assign in_frame  = (state != ST_WAIT_FRAME);
    assign emit_full = in_frame & pending;
    assign emit_part = (state == ST_ACTIVE) & de_fall & (fill != '0);
    assign emit      = ~vs_rise & (emit_full | emit_part);
    assign capture   = in_frame & ~vs_rise & I_rgb_de;

    // Outgoing batch: real slots from the assembly register, the rest zero or padded
    always_comb begin
        slot_used = '0;
        emit_data = '0;
        for (int k = 0; k < int'(BATCH_SIZE); k++) begin
            slot_used[k] = emit_full | (k < int'(fill));
        end
        for (int c = 0; c < int'(CHANNEL_COUNT); c++) begin
            for (int k = 0; k < int'(BATCH_SIZE); k++) begin
                if (slot_used[k]) begin
                    emit_data[c*LANE_BITS + k*PIXEL_BITS +: PIXEL_BITS] =
                        asm_data[c*LANE_BITS + k*PIXEL_BITS +: PIXEL_BITS];
                end
`ifdef INPUT_PACKER_PAD_REPEAT_EN
                else if (fill != '0) begin
                    emit_data[c*LANE_BITS + k*PIXEL_BITS +: PIXEL_BITS] =
                        asm_data[c*LANE_BITS + (int'(fill) - 1)*PIXEL_BITS +: PIXEL_BITS];
                end
`endif
            end
        end
    end

    always_ff @(posedge I_rgb_clk) begin
        if (I_rst) begin
            state         <= ST_WAIT_FRAME;
            de_q          <= 1'b0;
            vs_q          <= 1'b0;
            fill          <= '0;
            pending       <= 1'b0;
            asm_data      <= '0;
            addr_cnt      <= '0;
            addr_full     <= 1'b0;
            row_cnt       <= '0;
            row_full      <= 1'b0;
            first_flag    <= 1'b0;
            pix_cnt       <= '0;
            O_batch_valid <= 1'b0;
            O_batch_data  <= '0;
            O_batch_mask  <= '0;
            O_batch_addr  <= '0;
            O_batch_row   <= '0;
            O_batch_first <= 1'b0;
            O_batch_last  <= 1'b0;
            O_line_width  <= '0;
            O_overflow    <= 1'b0;
        end else begin
            de_q          <= I_rgb_de;
            vs_q          <= I_rgb_vs;
            O_batch_valid <= 1'b0;

            if (vs_rise) begin
                // Frame start: drop any batch in flight and restart line/row tracking
                state      <= ST_IDLE;
                fill       <= '0;
                pending    <= 1'b0;
                addr_cnt   <= '0;
                addr_full  <= 1'b0;
                row_cnt    <= '0;
                row_full   <= 1'b0;
                first_flag <= 1'b1;
                pix_cnt    <= '0;
                O_overflow <= 1'b0;
            end else if (in_frame) begin
                pending <= 1'b0;

                if (emit) begin
                    O_batch_valid <= 1'b1;
                    O_batch_data  <= emit_data;
                    O_batch_mask  <= slot_used;
                    O_batch_addr  <= addr_cnt;
                    O_batch_row   <= row_cnt;
                    O_batch_first <= first_flag;
                    O_batch_last  <= ~I_rgb_de;
                    first_flag    <= 1'b0;
                    if (addr_full || row_full) begin
                        O_overflow <= 1'b1;
                    end
                    // A batch is last when DE is already low at the emission edge
                    if (!I_rgb_de) begin
                        addr_cnt  <= '0;
                        addr_full <= 1'b0;
                        if (row_cnt == ROW_BITS'(MAX_HEIGHT - 1)) begin
                            row_full <= 1'b1;
                        end else begin
                            row_cnt <= row_cnt + ROW_BITS'(1);
                        end
                    end else if (addr_cnt == ADDR_BITS'(MAX_BATCHES - 1)) begin
                        addr_full <= 1'b1;
                    end else begin
                        addr_cnt <= addr_cnt + ADDR_BITS'(1);
                    end
                end

                if (capture) begin
                    state <= ST_ACTIVE;
                    for (int c = 0; c < int'(CHANNEL_COUNT); c++) begin
                        asm_data[c*LANE_BITS + int'(fill)*PIXEL_BITS +: PIXEL_BITS] <=
                            I_rgb_color[c*PIXEL_BITS +: PIXEL_BITS];
                    end
                    if (fill == FILL_BITS'(BATCH_SIZE - 1)) begin
                        fill    <= '0;
                        pending <= 1'b1;
                    end else begin
                        fill <= fill + FILL_BITS'(1);
                    end
                    if (pix_cnt != WIDTH_BITS'(MAX_WIDTH)) begin
                        pix_cnt <= pix_cnt + WIDTH_BITS'(1);
                    end
                end else if (de_fall && (state == ST_ACTIVE)) begin
                    state        <= ST_IDLE;
                    fill         <= '0;
                    O_line_width <= pix_cnt;
                    pix_cnt      <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_input_batch_packer.sv
// Self-checking bench for input_batch_packer: expected batches queued at stimulus time, checked by a monitor.
`timescale 1ns/1ps
module tb_input_batch_packer;

    localparam int unsigned CH   = 3;
    localparam int unsigned PB   = 8;
    localparam int unsigned BS   = 4;
    localparam int unsigned MW   = 16;
    localparam int unsigned MH   = 4;
    localparam int unsigned LANE = BS * PB;
    localparam int unsigned DW   = CH * LANE;

    logic          clk = 1'b0;
    logic          rst;
    logic          de;
    logic          vs;
    logic [CH*PB-1:0] color;
    logic          valid;
    logic [DW-1:0] data;
    logic [BS-1:0] mask;
    logic [1:0]    addr;
    logic [1:0]    row;
    logic          first;
    logic          last;
    logic [4:0]    line_width;
    logic          overflow;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [BS-1:0] mask;
        logic [1:0]    addr;
        logic [1:0]    row;
        logic          first;
        logic          last;
        logic          overflow;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   strobes = 0;

    input_batch_packer #(
        .CHANNEL_COUNT(CH),
        .PIXEL_BITS   (PB),
        .BATCH_SIZE   (BS),
        .MAX_WIDTH    (MW),
        .MAX_HEIGHT   (MH)
    ) dut (
        .I_rgb_clk    (clk),
        .I_rst        (rst),
        .I_rgb_de     (de),
        .I_rgb_vs     (vs),
        .I_rgb_color  (color),
        .O_batch_valid(valid),
        .O_batch_data (data),
        .O_batch_mask (mask),
        .O_batch_addr (addr),
        .O_batch_row  (row),
        .O_batch_first(first),
        .O_batch_last (last),
        .O_line_width (line_width),
        .O_overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    function automatic logic [7:0] pix(input int v, input int c);
        return 8'(v + c * 64);
    endfunction

    // Monitor: every strobe is matched against the oldest queued expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (valid === 1'b1) begin
            strobes++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got strobe addr=%0d row=%0d mask=%h, required none", addr, row, mask);
            end else begin
                e = exp_q.pop_front();
                check("batch_data",  data,              e.data);
                check("batch_mask",  DW'(mask),         DW'(e.mask));
                check("batch_addr",  DW'(addr),         DW'(e.addr));
                check("batch_row",   DW'(row),          DW'(e.row));
                check("batch_first", DW'(first),        DW'(e.first));
                check("batch_last",  DW'(last),         DW'(e.last));
                check("overflow_at_strobe", DW'(overflow), DW'(e.overflow));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic [BS-1:0] m, input logic [1:0] a,
                            input logic [1:0] r, input logic f, input logic l, input logic o);
        exp_t e;
        e.data = d; e.mask = m; e.addr = a; e.row = r; e.first = f; e.last = l; e.overflow = o;
        exp_q.push_back(e);
    endtask

    task automatic drive_pixels(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            de    = 1'b1;
            color = {pix(start + i, 2), pix(start + i, 1), pix(start + i, 0)};
            tick();
        end
    endtask

    task automatic end_line();
        de    = 1'b0;
        color = '0;
        repeat (3) tick();
    endtask

    task automatic vs_pulse();
        vs = 1'b1;
        tick();
        vs = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},      DW'(valid),      '0);
        check({tag, "_data"},       data,            '0);
        check({tag, "_mask"},       DW'(mask),       '0);
        check({tag, "_addr"},       DW'(addr),       '0);
        check({tag, "_row"},        DW'(row),        '0);
        check({tag, "_first"},      DW'(first),      '0);
        check({tag, "_last"},       DW'(last),       '0);
        check({tag, "_line_width"}, DW'(line_width), '0);
        check({tag, "_overflow"},   DW'(overflow),   '0);
    endtask

    initial begin
        rst = 1'b1; de = 1'b0; vs = 1'b0; color = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Pixels before any frame start are ignored
        drive_pixels(8'h01, 8);
        end_line();
        check_all_zero("no_frame");

        // Two full batches on row 0
        vs_pulse();
        push_exp(96'h84838281_44434241_04030201, 4'hF, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        push_exp(96'h88878685_48474645_08070605, 4'hF, 2'd1, 2'd0, 1'b0, 1'b1, 1'b0);
        drive_pixels(8'h01, 8);
        end_line();
        check("line_width_8", DW'(line_width), DW'(8));

        // Full batch then a 2-pixel partial flush on row 1
        push_exp(96'h94939291_54535251_14131211, 4'hF, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0);
`ifdef INPUT_PACKER_PAD_REPEAT_EN
        push_exp(96'h96969695_56565655_16161615, 4'b0011, 2'd1, 2'd1, 1'b0, 1'b1, 1'b0);
`else
        push_exp(96'h00009695_00005655_00001615, 4'b0011, 2'd1, 2'd1, 1'b0, 1'b1, 1'b0);
`endif
        drive_pixels(8'h11, 6);
        end_line();
        check("line_width_6", DW'(line_width), DW'(6));

        // 20-pixel line: address saturates and the fifth batch flags overflow
        push_exp(96'hA4A3A2A1_64636261_24232221, 4'hF, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0);
        push_exp(96'hA8A7A6A5_68676665_28272625, 4'hF, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0);
        push_exp(96'hACABAAA9_6C6B6A69_2C2B2A29, 4'hF, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0);
        push_exp(96'hB0AFAEAD_706F6E6D_302F2E2D, 4'hF, 2'd3, 2'd2, 1'b0, 1'b0, 1'b0);
        push_exp(96'hB4B3B2B1_74737271_34333231, 4'hF, 2'd3, 2'd2, 1'b0, 1'b1, 1'b1);
        drive_pixels(8'h21, 20);
        end_line();
        check("line_width_sat", DW'(line_width), DW'(16));
        check("overflow_sticky", DW'(overflow), DW'(1));

        // Frame start mid-line, coinciding with DE falling: nothing emitted
        drive_pixels(8'h41, 3);
        de = 1'b0; color = '0; vs = 1'b1;
        tick();
        vs = 1'b0;
        tick();
        check("overflow_cleared", DW'(overflow), '0);
        check("line_width_held", DW'(line_width), DW'(16));
        push_exp(96'hD4D3D2D1_94939291_54535251, 4'hF, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        drive_pixels(8'h51, 4);
        end_line();
        check("line_width_4", DW'(line_width), DW'(4));

        // Reset just after a completing pixel drops the pending batch
        drive_pixels(8'h61, 4);
        de = 1'b0; color = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("mid_batch_reset");
        tick();
        drive_pixels(8'h61, 4);
        end_line();
        check_all_zero("wait_after_reset");

        // Recovery: new frame with a 3-pixel partial line
        vs_pulse();
`ifdef INPUT_PACKER_PAD_REPEAT_EN
        push_exp(96'hF3F3F2F1_B3B3B2B1_73737271, 4'b0111, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0);
`else
        push_exp(96'h00F3F2F1_00B3B2B1_00737271, 4'b0111, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0);
`endif
        drive_pixels(8'h71, 3);
        end_line();
        check("line_width_3", DW'(line_width), DW'(3));

        repeat (3) tick();
        check("pending_expectations", DW'(exp_q.size()), '0);
        check("strobe_count", DW'(strobes), DW'(11));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
